dwt53_update_stage: RTL

//  Parametrised LeGall 5/3 lifting update step for the DWT datapath.

---
 rtl/dwt_pkg.sv | 41 ++++
 rtl/dwt_pipe_reg.sv | 44 ++++
 rtl/dwt53_update_stage.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/dwt_pkg.sv
// -----------------------------------------------------------------------------
// dwt_pkg
// Shared constants, types and helpers for the LeGall 5/3 lifting datapath.
//   ROUND_OFS / UPD_SHIFT : rounding offset and shift of the update step
//   UPD_MAX_DATA_W        : widest even-sample width the P1 record can hold
//   upd_p1_t              : P1 record {sum, even, first}. Fields are sized for
//                           UPD_MAX_DATA_W and hold sign-extended values.
//   sat_signed()          : clamps a signed value to a given two's-complement
//                           width.
// -----------------------------------------------------------------------------
package dwt_pkg;

  localparam int ROUND_OFS      = 2;
  localparam int UPD_SHIFT      = 2;

  // Instances must use DATA_W <= UPD_MAX_DATA_W.
  localparam int UPD_MAX_DATA_W = 16;
  localparam int UPD_SUM_MAX_W  = UPD_MAX_DATA_W + 3;

  typedef struct packed {
    logic signed [UPD_SUM_MAX_W-1:0]  sum;
    logic signed [UPD_MAX_DATA_W-1:0] even;
    logic                             first;
  } upd_p1_t;

  // Clamp value into [-2^(width-1), 2^(width-1)-1]. width must be in 1..31.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                    input int                 width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/dwt_pipe_reg.sv
// -----------------------------------------------------------------------------
// dwt_pipe_reg
// One valid/ready register slice. The slice loads whenever it is empty or its
// content leaves in the same cycle. No bubble and no skid buffer.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid / in_ready upstream handshake (in_ready depends combinationally
//                       on out_ready)
//   in_data             payload captured on in_valid && in_ready
//   out_valid/out_ready downstream handshake
//   out_data            registered payload. Held while out_valid && !out_ready.
// -----------------------------------------------------------------------------
module dwt_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, whatever the order the simulator evaluates blocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      // NOTE: the payload is reset as well as the valid bit. Downstream reads
      // m_coarse/m_first as defined zeros after reset, not just "don't care".
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/dwt53_update_stage.sv
// -----------------------------------------------------------------------------
// dwt53_update_stage
// LeGall 5/3 lifting update step:
//   s[n] = x[2n] + ((d[n-1] + d[n] + 2) >>> 2)
// The stage has two register slices, P1 and P2. Latency is 2 clk and the
// throughput is one pair per clk. The line start uses symmetric extension
// (d[-1] = d[0]).
//
// Build option: define DWT_UPDATE_SAT_EN to clamp the result to OUT_W bits and
// to expose sat_flag. Without it, the result wraps to OUT_W bits.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   s_valid/ready input pair handshake. s_ready is 0 during reset.
//   s_even        signed even sample x[2n]           (DATA_W)
//   s_detail      signed detail coefficient d[n]     (DATA_W+1)
//   s_first       pair is the first of a line
//   m_valid/ready output handshake
//   m_coarse      signed coarse coefficient s[n]     (OUT_W)
//   m_first       s_first carried along with its result
//   coarse_cnt    output transfers, wrapping         (CNT_W)
//   err_no_first  sticky: a pair arrived with no earlier detail to pair with
//   sat_flag      (DWT_UPDATE_SAT_EN only) result was clamped
// -----------------------------------------------------------------------------
module dwt53_update_stage
  import dwt_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OUT_W  = DATA_W + 1,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_even,
  input  logic signed [DATA_W:0]   s_detail,
  input  logic                     s_first,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [OUT_W-1:0]  m_coarse,
  output logic                     m_first,
  output logic [CNT_W-1:0]         coarse_cnt,
  output logic                     err_no_first
`ifdef DWT_UPDATE_SAT_EN
  ,
  output logic                     sat_flag
`endif
);

  localparam int SUM_W = DATA_W + 3;
  localparam int P1_W  = 1 + DATA_W + SUM_W;
`ifdef DWT_UPDATE_SAT_EN
  localparam int P2_W  = OUT_W + 2;
`else
  localparam int P2_W  = OUT_W + 1;
`endif
  localparam logic signed [SUM_W-1:0] ROUND = SUM_W'(ROUND_OFS);

  // Handshake between the slices
  logic p1_in_ready;
  logic p1_valid;
  logic p2_in_ready;

  // Line context
  logic signed [DATA_W:0] d_prev;
  logic                   have_prev;
  logic                   in_xfer;
  logic                   treat_first;
  logic signed [DATA_W:0] dl;
  logic signed [SUM_W-1:0] sum;

  // Slice payloads
  logic [P1_W-1:0] p1_in_vec;
  logic [P1_W-1:0] p1_out_vec;
  upd_p1_t         p1_q;
  logic signed [UPD_SUM_MAX_W-1:0] full_w;
  logic signed [OUT_W-1:0]         coarse;
  logic [P2_W-1:0] p2_in_vec;
  logic [P2_W-1:0] p2_out_vec;

  // ---------------------------------------------------------------------------
  // Input side
  // ---------------------------------------------------------------------------
  assign s_ready = p1_in_ready && !rst;
  assign in_xfer = s_valid && s_ready;

  // A pair with no earlier detail in the line pairs with itself, the same way
  // as an explicit line start.
  assign treat_first = s_first || !have_prev;
  assign dl          = treat_first ? s_detail : d_prev;
  assign sum         = SUM_W'(dl) + SUM_W'(s_detail) + ROUND;

  assign p1_in_vec = {s_first, s_even, sum};

  always_ff @(posedge clk) begin
    if (rst) begin
      d_prev       <= '0;
      have_prev    <= 1'b0;
      err_no_first <= 1'b0;
    end else if (in_xfer) begin
      d_prev    <= s_detail;
      have_prev <= 1'b1;
      if (!s_first && !have_prev) begin
        err_no_first <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // P1: holds {first, even, sum} at their exact widths
  // ---------------------------------------------------------------------------
  dwt_pipe_reg #(
    .W (P1_W)
  ) u_p1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_valid),
    .in_ready  (p1_in_ready),
    .in_data   (p1_in_vec),
    .out_valid (p1_valid),
    .out_ready (p2_in_ready),
    .out_data  (p1_out_vec)
  );

  // Widen the P1 slice into the shared record. The fields are sign-extended,
  // so the arithmetic below can use whole fields.
  // NOTE: every always_comb output gets a value before any conditional logic,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    p1_q       = '0;
    p1_q.sum   = UPD_SUM_MAX_W'(signed'(p1_out_vec[SUM_W-1:0]));
    p1_q.even  = UPD_MAX_DATA_W'(signed'(p1_out_vec[SUM_W +: DATA_W]));
    p1_q.first = p1_out_vec[P1_W-1];
  end

  // The value fits in DATA_W+2 bits. The wider container only keeps the
  // clamp comparison simple.
  assign full_w = UPD_SUM_MAX_W'(p1_q.even) + (p1_q.sum >>> UPD_SHIFT);

  // ---------------------------------------------------------------------------
  // Reduce to OUT_W
  // ---------------------------------------------------------------------------
`ifdef DWT_UPDATE_SAT_EN
  logic signed [31:0] sat_w;
  logic               sat_hit;
  logic               unused_sat_msbs;

  assign sat_w           = sat_signed(32'(full_w), OUT_W);
  assign sat_hit         = (sat_w != 32'(full_w));
  assign coarse          = sat_w[OUT_W-1:0];
  assign unused_sat_msbs = ^sat_w[31:OUT_W];
  assign p2_in_vec       = {sat_hit, p1_q.first, coarse};
`else
  logic unused_full_msbs;

  assign coarse           = full_w[OUT_W-1:0];
  assign unused_full_msbs = ^full_w[UPD_SUM_MAX_W-1:OUT_W];
  assign p2_in_vec        = {p1_q.first, coarse};
`endif

  // ---------------------------------------------------------------------------
  // P2: registered output
  // ---------------------------------------------------------------------------
  dwt_pipe_reg #(
    .W (P2_W)
  ) u_p2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (p1_valid),
    .in_ready  (p2_in_ready),
    .in_data   (p2_in_vec),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .out_data  (p2_out_vec)
  );

  assign m_coarse = p2_out_vec[OUT_W-1:0];
  assign m_first  = p2_out_vec[OUT_W];
`ifdef DWT_UPDATE_SAT_EN
  assign sat_flag = p2_out_vec[OUT_W+1];
`endif

  // ---------------------------------------------------------------------------
  // Output transfer counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      coarse_cnt <= '0;
    end else if (m_valid && m_ready) begin
      coarse_cnt <= coarse_cnt + CNT_W'(1);
    end
  end

endmodule
